// File: rtl/bus_master.sv
// bus_master: root of the register bus tree. Turns a valid/ready command stream into
// single bus transactions on bus_in, collects read data/ack/irq from bus_out and
// returns one response per command. Only one transaction is outstanding at a time.
//
// bus_in layout : [0] clk, [1] reset_l, [2] startup, [3] req, [4] rd_wr_l,
//                 [20:5] address, [36:21] write data
// bus_out layout: [15:0] read data, [16] read ack, [17] irq
//
// Ports:
//   clk, reset           - system clock, synchronous active-high reset
//   cmd_valid/cmd_ready  - command handshake; cmd_rd_wr_l (1 = read), cmd_addr, cmd_wr_data
//   rsp_valid/rsp_ready  - response handshake; rsp_rd_data, rsp_err (read timeout)
//   bus_in / bus_out     - downstream bus
//   irq                  - bus_out irq field, registered once
module bus_master #(
  parameter int unsigned TIMEOUT        = 255,
  parameter int unsigned STARTUP_CYCLES = 16,
  localparam int BUS_ADDR_START = 5,
  localparam int BUS_ADDR_END   = 21,
  localparam int BUS_DATA_START = 21,
  localparam int BUS_DATA_END   = 37,
  localparam int BUS_IN_WIDTH   = 37,
  localparam int BUS_OUT_WIDTH  = 18
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  cmd_valid,
  output logic                                  cmd_ready,
  input  logic                                  cmd_rd_wr_l,
  input  logic [BUS_ADDR_END-BUS_ADDR_START-1:0] cmd_addr,
  input  logic [BUS_DATA_END-BUS_DATA_START-1:0] cmd_wr_data,
  output logic                                  rsp_valid,
  input  logic                                  rsp_ready,
  output logic [BUS_DATA_END-BUS_DATA_START-1:0] rsp_rd_data,
  output logic                                  rsp_err,
  output logic [BUS_IN_WIDTH-1:0]               bus_in,
  input  logic [BUS_OUT_WIDTH-1:0]              bus_out,
  output logic                                  irq
);

  localparam int AddrW = BUS_ADDR_END - BUS_ADDR_START;
  localparam int DataW = BUS_DATA_END - BUS_DATA_START;

  localparam int BUS_FIELD_CLK     = 0;
  localparam int BUS_FIELD_RESET_L = 1;
  localparam int BUS_FIELD_STARTUP = 2;
  localparam int BUS_FIELD_REQ     = 3;
  localparam int BUS_FIELD_RD_WR_L = 4;
  localparam int BUS_OUT_ACK       = 16;
  localparam int BUS_OUT_IRQ       = 17;

  localparam logic [15:0] TimeoutVal = 16'(TIMEOUT);
  localparam logic [15:0] StartupVal = 16'(STARTUP_CYCLES);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  state_e             state_q, state_d;
  logic               rd_wr_l_q, rd_wr_l_d;
  logic [AddrW-1:0]   addr_q, addr_d;
  logic [DataW-1:0]   wr_data_q, wr_data_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [DataW-1:0]   rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;
  logic               reset_l_q;
  logic               startup_q;
  logic [15:0]        startup_cnt_q;
  logic               irq_q;

  always_ff @(posedge clk) begin
    reset_l_q <= ~reset;
    if (reset) begin
      state_q       <= StIdle;
      rd_wr_l_q     <= 1'b0;
      addr_q        <= '0;
      wr_data_q     <= '0;
      cnt_q         <= '0;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
      startup_q     <= 1'b0;
      startup_cnt_q <= StartupVal;
      irq_q         <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_wr_l_q  <= rd_wr_l_d;
      addr_q     <= addr_d;
      wr_data_q  <= wr_data_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      irq_q      <= bus_out[BUS_OUT_IRQ];
      // Startup is raised on the first edge with reset low and held for exactly
      // STARTUP_CYCLES cycles.
      if (startup_cnt_q != 16'd0) begin
        startup_q     <= 1'b1;
        startup_cnt_q <= startup_cnt_q - 16'd1;
      end else begin
        startup_q <= 1'b0;
      end
    end
  end

  // Combinational reset term keeps commands blocked in the first reset cycle too.
  assign cmd_ready = (state_q == StIdle) && reset_l_q && !startup_q && !reset;

  always_comb begin
    state_d    = state_q;
    rd_wr_l_d  = rd_wr_l_q;
    addr_d     = addr_q;
    wr_data_d  = wr_data_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready) begin
          rd_wr_l_d = cmd_rd_wr_l;
          addr_d    = cmd_addr;
          wr_data_d = cmd_wr_data;
          state_d   = StReq;
        end
      end
      StReq: begin
        if (rd_wr_l_q) begin
          cnt_d   = 16'd0;
          state_d = StWait;
        end else begin
          rsp_err_d  = 1'b0;
          rsp_data_d = '0;
          state_d    = StResp;
        end
      end
      StWait: begin
        // An ack wins over a timeout reached in the same cycle.
        if (bus_out[BUS_OUT_ACK]) begin
          rsp_data_d = bus_out[DataW-1:0];
          rsp_err_d  = 1'b0;
          state_d    = StResp;
        end else begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_d == TimeoutVal) begin
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
            state_d    = StResp;
          end
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus_in                                    = '0;
    bus_in[BUS_FIELD_CLK]                     = clk;
    bus_in[BUS_FIELD_RESET_L]                 = reset_l_q;
    bus_in[BUS_FIELD_STARTUP]                 = startup_q;
    bus_in[BUS_FIELD_REQ]                     = (state_q == StReq);
    bus_in[BUS_FIELD_RD_WR_L]                 = rd_wr_l_q;
    bus_in[BUS_ADDR_END-1:BUS_ADDR_START]     = addr_q;
    bus_in[BUS_DATA_END-1:BUS_DATA_START]     = wr_data_q;
  end

  assign rsp_valid   = (state_q == StResp);
  assign rsp_rd_data = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_bus_master.sv
module tb_bus_master;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_rd_wr_l;
  logic [15:0] cmd_addr;
  logic [15:0] cmd_wr_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_rd_data;
  logic        rsp_err;
  logic [36:0] bus_in;
  logic [17:0] bus_out;
  logic        irq;

  logic        tb_ack;
  logic        tb_irq;
  logic [15:0] tb_rdata;
  assign bus_out = {tb_irq, tb_ack, tb_rdata};

  logic        b_clk, b_reset_l, b_startup, b_req, b_rw;
  logic [15:0] b_addr, b_wdata;
  assign b_clk     = bus_in[0];
  assign b_reset_l = bus_in[1];
  assign b_startup = bus_in[2];
  assign b_req     = bus_in[3];
  assign b_rw      = bus_in[4];
  assign b_addr    = bus_in[20:5];
  assign b_wdata   = bus_in[36:21];

  bus_master #(
    .TIMEOUT       (8),
    .STARTUP_CYCLES(16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_rd_wr_l(cmd_rd_wr_l),
    .cmd_addr   (cmd_addr),
    .cmd_wr_data(cmd_wr_data),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rd_data(rsp_rd_data),
    .rsp_err    (rsp_err),
    .bus_in     (bus_in),
    .bus_out    (bus_out),
    .irq        (irq)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // irq reference: bus_out irq delayed one clock, cleared by reset.
  logic irq_exp;
  bit   irq_chk = 1'b0;
  always @(posedge clk) irq_exp <= reset ? 1'b0 : tb_irq;
  always @(negedge clk) begin
    if (irq_chk) begin
      chk("irq_delay", 32'(irq), 32'(irq_exp));
      chk("bus_clk_low", 32'(b_clk), 32'(clk));
    end
  end

  initial begin
    tb_irq = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tb_irq = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  typedef struct {
    logic        rd;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          ack_k;     // WAIT cycle (1-based) carrying the ack, 0 = no ack
    logic [15:0] ack_data;
    bit          stray_req; // drive an ack during the REQ cycle
    int          exp_c;     // cycles from REQ to first rsp_valid
    logic        exp_err;
    logic [15:0] exp_data;
    int          hold;      // cycles rsp_ready is kept low once rsp_valid is seen
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input vec_t v);
    int c;
    bit got;
    cmd_valid   = 1'b1;
    cmd_rd_wr_l = v.rd;
    cmd_addr    = v.addr;
    cmd_wr_data = v.wdata;
    rsp_ready   = 1'b0;
    chk("ready_in_idle", 32'(cmd_ready), 32'(1));
    step();
    cmd_valid = 1'b0;
    chk("req_high", 32'(b_req), 32'(1));
    chk("req_addr", 32'(b_addr), 32'(v.addr));
    chk("req_rd_wr_l", 32'(b_rw), 32'(v.rd));
    chk("req_wdata", 32'(b_wdata), 32'(v.wdata));
    chk("no_ready_in_req", 32'(cmd_ready), 32'(0));
    c   = 0;
    got = 1'b0;
    while (!got && c < 40) begin
      tb_ack   = (v.ack_k != 0 && c == v.ack_k) || (c == 0 && v.stray_req);
      tb_rdata = tb_ack ? ((c == 0) ? 16'h5555 : v.ack_data) : 16'hDEAD;
      step();
      c++;
      tb_ack = 1'b0;
      if (c == 1) chk("req_one_cycle", 32'(b_req), 32'(0));
      if (rsp_valid) got = 1'b1;
      else if (v.rd) chk("addr_held", 32'(b_addr), 32'(v.addr));
    end
    chk("rsp_latency", 32'(c), 32'(v.exp_c));
    chk("rsp_err", 32'(rsp_err), 32'(v.exp_err));
    chk("rsp_data", 32'(rsp_rd_data), 32'(v.exp_data));
    for (int h = 0; h < v.hold; h++) begin
      tb_ack   = 1'b1;  // ignored in RESP
      tb_rdata = 16'hBAD0;
      step();
      chk("hold_valid", 32'(rsp_valid), 32'(1));
      chk("hold_err", 32'(rsp_err), 32'(v.exp_err));
      chk("hold_data", 32'(rsp_rd_data), 32'(v.exp_data));
      chk("hold_no_ready", 32'(cmd_ready), 32'(0));
    end
    tb_ack    = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rsp_dropped", 32'(rsp_valid), 32'(0));
    chk("back_to_idle", 32'(cmd_ready), 32'(1));
  endtask

  task automatic check_startup(input string tag);
    for (int i = 0; i < 20; i++) begin
      step();
      chk({tag, "_reset_l"}, 32'(b_reset_l), 32'(1));
      chk({tag, "_startup"}, 32'(b_startup), 32'(i < 16));
      chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'(i >= 16));
      chk({tag, "_no_rsp"}, 32'(rsp_valid), 32'(0));
    end
  endtask

  initial begin
    int acc[$];
    vecs[0] = '{1'b0, 16'h0040, 16'hA5A5, 0, 16'h0000, 1'b0, 1, 1'b0, 16'h0000, 0};
    vecs[1] = '{1'b1, 16'h0104, 16'h0000, 3, 16'h1234, 1'b0, 4, 1'b0, 16'h1234, 5};
    vecs[2] = '{1'b1, 16'h0200, 16'h0000, 0, 16'h0000, 1'b1, 9, 1'b1, 16'h0000, 2};
    vecs[3] = '{1'b1, 16'h0300, 16'h0000, 8, 16'hBEEF, 1'b0, 9, 1'b0, 16'hBEEF, 1};
    vecs[4] = '{1'b1, 16'h0008, 16'h0000, 1, 16'h0001, 1'b0, 2, 1'b0, 16'h0001, 0};
    vecs[5] = '{1'b0, 16'hFFFF, 16'h5A5A, 0, 16'h0000, 1'b0, 1, 1'b0, 16'h0000, 1};
    vecs[6] = '{1'b1, 16'h8001, 16'h0000, 7, 16'hC3C3, 1'b0, 8, 1'b0, 16'hC3C3, 0};

    reset       = 1'b1;
    cmd_valid   = 1'b0;
    cmd_rd_wr_l = 1'b0;
    cmd_addr    = '0;
    cmd_wr_data = '0;
    rsp_ready   = 1'b0;
    tb_ack      = 1'b0;
    tb_rdata    = '0;

    // Reset held for three edges.
    step();
    irq_chk = 1'b1;
    chk("rst_reset_l", 32'(b_reset_l), 32'(0));
    chk("rst_startup", 32'(b_startup), 32'(0));
    chk("rst_cmd_ready", 32'(cmd_ready), 32'(0));
    chk("rst_req", 32'(b_req), 32'(0));
    chk("rst_rw", 32'(b_rw), 32'(0));
    chk("rst_addr", 32'(b_addr), 32'(0));
    chk("rst_wdata", 32'(b_wdata), 32'(0));
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_rsp_err", 32'(rsp_err), 32'(0));
    chk("rst_rsp_data", 32'(rsp_rd_data), 32'(0));
    chk("bus_clk_high", 32'(b_clk), 32'(clk));
    step();
    step();
    chk("rst_cmd_ready_3", 32'(cmd_ready), 32'(0));
    reset = 1'b0;
    check_startup("startup");

    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-to-back writes: one accept every third cycle.
    cmd_valid   = 1'b1;
    cmd_rd_wr_l = 1'b0;
    cmd_addr    = 16'h0010;
    cmd_wr_data = 16'h1111;
    rsp_ready   = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (cmd_ready) acc.push_back(i);
      step();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    chk("b2b_count", 32'(acc.size()), 32'(3));
    if (acc.size() >= 3) begin
      chk("b2b_first", 32'(acc[0]), 32'(0));
      chk("b2b_gap1", 32'(acc[1]), 32'(3));
      chk("b2b_gap2", 32'(acc[2]), 32'(6));
    end
    chk("b2b_idle", 32'(cmd_ready), 32'(1));

    // Stray ack while idle must not produce or pre-load a response.
    tb_ack   = 1'b1;
    tb_rdata = 16'h7777;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stray_no_rsp", 32'(rsp_valid), 32'(0));
      chk("stray_no_req", 32'(b_req), 32'(0));
    end
    tb_ack = 1'b0;
    run_vec(vecs[2]);

    // Reset in the middle of a read.
    cmd_valid   = 1'b1;
    cmd_rd_wr_l = 1'b1;
    cmd_addr    = 16'h0104;
    step();
    cmd_valid = 1'b0;
    chk("mid_req", 32'(b_req), 32'(1));
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_req_low", 32'(b_req), 32'(0));
    chk("mid_rsp_low", 32'(rsp_valid), 32'(0));
    chk("mid_ready_low", 32'(cmd_ready), 32'(0));
    chk("mid_reset_l", 32'(b_reset_l), 32'(0));
    tb_ack   = 1'b1;  // late ack from the abandoned read
    tb_rdata = 16'h4321;
    check_startup("restart");
    tb_ack = 1'b0;
    run_vec(vecs[1]);

    step();
    irq_chk = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_master.md
Name: bus_master

Overview:
- Host-side bus master at the root of a register bus tree; drives the upstream `bus_in` consumed by window and register blocks, and collects their `bus_out`.
- Converts a valid/ready command interface (from a UART/JTAG/CPU bridge) into single bus transactions.
- Generates read responses with a timeout error.
- One outstanding transaction at a time.

Parameters:
- TIMEOUT, 255: cycles to wait for read acknowledge after `bus_req` before reporting an error; legal range 1..65535.
- STARTUP_CYCLES, 16: cycles after reset release during which `bus_startup` is held high; 0 disables it.

Ports:
- clk  input  1  system clock; forwarded as bus clock.
- reset  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command accepted when `cmd_valid && cmd_ready`.
- cmd_rd_wr_l  input  1  1 = read, 0 = write.
- cmd_addr  input  BUS_ADDR_END-BUS_ADDR_START  byte address.
- cmd_wr_data  input  BUS_DATA_END-BUS_DATA_START  write data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  response consumed when `rsp_valid && rsp_ready`.
- rsp_rd_data  output  BUS_DATA_END-BUS_DATA_START  read data (0 for writes and errors).
- rsp_err  output  1  read timed out.
- bus_in  output  BUS_IN_WIDTH  bus to downstream windows/registers.
- bus_out  input  BUS_OUT_WIDTH  returned read data, read acknowledge, irq.
- irq  output  1  `bus_out` irq field, registered once.

Behaviour:
- Clock and reset:
  - One clock; reset is synchronous and active-high.
  - Ports are named clk and reset.
- Fixed `bus_in` field drives:
  - BUS_FIELD_CLK = clk (combinational).
  - BUS_FIELD_RESET_L = registered `~reset`, so it is low the cycle after reset is sampled high.
  - BUS_FIELD_STARTUP is high for STARTUP_CYCLES cycles after the first cycle with reset low, then 0 until the next reset.
- Reset values:
  - `cmd_ready` = 0 during reset and while startup is active.
  - `rsp_valid` = 0, `rsp_err` = 0, `rsp_rd_data` = 0, `irq` = 0.
  - Bus REQ = 0, RD_WR_L = 0, address = 0, write data = 0.
  - State = IDLE, timeout counter = 0.
- State machine: IDLE, REQ, WAIT, RESP.
  - IDLE:
    - `cmd_ready` = 1 once startup is done.
    - On accept, latch rd_wr_l/addr/wr_data and go to REQ.
  - REQ:
    - BUS_FIELD_REQ = 1 for exactly this one cycle, with addr, data and rd_wr_l stable.
    - Write: go to RESP with `rsp_err` = 0 and `rsp_rd_data` = 0.
    - Read: clear the counter and go to WAIT.
  - WAIT:
    - REQ = 0; addr and rd_wr_l stay held.
    - Read ack seen this cycle: capture rd data, `rsp_err` = 0, go to RESP.
    - Otherwise the counter increments; when it reaches TIMEOUT, `rsp_err` = 1, `rsp_rd_data` = 0, go to RESP.
    - An ack on the same cycle the counter reaches TIMEOUT wins: no error.
  - RESP:
    - `rsp_valid` = 1; outputs are held stable until `rsp_ready`.
    - On handshake, return to IDLE.
    - `cmd_ready` is 0 in RESP, so there is no new command on the handshake cycle.
- Read acknowledge:
  - Sampled only in WAIT.
  - Acks arriving in IDLE/REQ/RESP are ignored; they are not stored or counted.
- Latency:
  - Command accepted at cycle T → REQ at T+1.
  - Write: `rsp_valid` at T+2.
  - Read with ack at cycle T+1+k (k ≥ 1): `rsp_valid` at T+2+k.
  - Read with no ack: `rsp_valid` at T+2+TIMEOUT.
- Throughput: maximum one transaction per 3 cycles (writes, `rsp_ready` held high).
- Reset mid-transaction:
  - Abandon everything; return to IDLE and drop any pending response.
  - REQ deasserts in the cycle after reset is sampled.
  - Startup sequence reruns.
- `irq`: `bus_out` irq field registered once, independent of state.
- Widths: the counter is 16 bits; no arithmetic is applied to the address; the address is passed unmodified.

Test Plan:
- Startup: assert reset for 3 cycles then release with STARTUP_CYCLES=16 → `bus_startup` high exactly 16 cycles; RESET_L low during reset and high from the cycle after reset release; `cmd_ready` first high the cycle after startup drops.
- Write: cmd write addr 0x40, data 0xA5A5 accepted at T → REQ=1 only at T+1 with addr 0x40, RD_WR_L=0, data 0xA5A5; `rsp_valid` at T+2, `rsp_err` = 0; back-to-back writes with `rsp_ready`=1 accepted every 3 cycles.
- Read with ack: read addr 0x104, model acks 3 cycles after REQ with data 0x1234 → `rsp_valid` one cycle after ack, `rsp_rd_data` = 0x1234, `rsp_err` = 0; response held stable with `rsp_ready`=0 for 5 cycles, released on `rsp_ready`.
- Timeout: TIMEOUT=8, read with no ack → `rsp_valid` at T+10, `rsp_err` = 1, data 0; ack exactly on cycle 8 of WAIT → no error, data captured; stray ack in IDLE → no response.
- Reset mid-read: assert reset during WAIT → REQ=0 and `rsp_valid`=0 next cycle, `cmd_ready`=0 until startup completes, late ack ignored.
- irq: toggle the `bus_out` irq field → `irq` follows with exactly 1-cycle delay in all states.
